// File: rtl/data_memory_responder_pkg.sv
// Shared load/store format codes, responder state encoding and format legality check
// for the data-memory responder.
package data_memory_responder_pkg;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;
  localparam logic [2:0] F_SB  = 3'b000;
  localparam logic [2:0] F_SH  = 3'b001;
  localparam logic [2:0] F_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rsp_state_t;

  function automatic logic format_illegal(input logic write, input logic [2:0] fmt);
    if (write) return !(fmt inside {F_SB, F_SH, F_SW});
    return fmt inside {3'b011, 3'b110, 3'b111};
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response bus between the pipeline memory stage (master) and the
// data-memory responder (slave).
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_format;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_format, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_format, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_memory_responder_mem_lane_aligner.sv
// Combinational byte-lane steering: store byte enables and replicated data,
// load extract/extend, and the alignment fault flag.
module mem_lane_aligner
  import data_memory_responder_pkg::*;
(
  input  logic [2:0]  format,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = wdata;
    misalign  = 1'b0;
    unique case (format[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      2'b10: begin
        byte_en  = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

  // A misaligned word load yields a shifted word here, but faulted results are discarded.
  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    load_data = 32'd0;
    unique case (format)
      F_LB:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F_LH:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F_LW:    load_data = shifted;
      F_LBU:   load_data = {24'd0, shifted[7:0]};
      F_LHU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: one outstanding request, programmable wait states,
// word RAM with byte-lane writes and one response beat per request.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_STATES = 2
) (
  input logic clock,
  input logic reset,
  data_memory_responder_if.slave bus
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  rsp_state_t  state_q, state_d;
  logic [3:0]  cnt_q;
  logic        lat_write;
  logic [31:0] lat_addr, lat_wdata;
  logic [2:0]  lat_format;
  logic        acc_write;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_format;
  logic [31:0] offset;
  logic        in_range;
  logic [IDX_W-1:0] idx;
  logic [3:0]  byte_en;
  logic [31:0] wdata_rep, load_data;
  logic        misalign, acc_error;
  logic        accept, commit;
  logic [31:0] rdata_q;
  logic        error_q;
  logic [31:0] mem [DEPTH_WORDS];

  assign accept        = bus.req_valid & bus.req_ready;
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;

  // With zero wait states the commit happens on the acceptance edge, before the latches fill.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write  = bus.req_write;
      acc_addr   = bus.req_addr;
      acc_wdata  = bus.req_wdata;
      acc_format = bus.req_format;
    end else begin
      acc_write  = lat_write;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
      acc_format = lat_format;
    end
  end

  assign offset    = acc_addr - BASE_ADDR;
  assign in_range  = (acc_addr >= BASE_ADDR) && (offset < SPAN);
  assign idx       = offset[IDX_W+1:2];
  assign acc_error = misalign | ~in_range | format_illegal(acc_write, acc_format);

  mem_lane_aligner u_aligner (
    .format    (acc_format),
    .addr_lo   (acc_addr[1:0]),
    .wdata     (acc_wdata),
    .rdata     (mem[idx]),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .load_data (load_data),
    .misalign  (misalign)
  );

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end
      end
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      rdata_q    <= 32'd0;
      error_q    <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_format <= 3'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lat_write  <= bus.req_write;
        lat_addr   <= bus.req_addr;
        lat_wdata  <= bus.req_wdata;
        lat_format <= bus.req_format;
      end
      if (state_q == ST_IDLE && state_d == ST_WAIT) cnt_q <= CNT_INIT;
      else if (state_q == ST_WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (commit) begin
        rdata_q <= (acc_write | acc_error) ? 32'd0 : load_data;
        error_q <= acc_error;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && commit && acc_write && !acc_error) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with two wait states,
// one with none, driven through the bus interface.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  data_memory_responder_if bus_a ();
  data_memory_responder_if bus_b ();

  data_memory_responder #(.WAIT_STATES(2)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  data_memory_responder #(.WAIT_STATES(0)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    if (sel == 0) begin
      bus_a.req_valid = v; bus_a.req_write = w; bus_a.req_addr = a;
      bus_a.req_wdata = d; bus_a.req_format = f;
    end else begin
      bus_b.req_valid = v; bus_b.req_write = w; bus_b.req_addr = a;
      bus_b.req_wdata = d; bus_b.req_format = f;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
  endfunction

  function automatic logic vld(input int sel);
    return (sel == 0) ? bus_a.rsp_valid : bus_b.rsp_valid;
  endfunction

  // Issues one request, waits for its response and completes the response handshake.
  // lat counts cycles from the acceptance edge until rsp_valid is seen; -1 on timeout.
  task automatic xact(input int sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, output logic [31:0] rd, output logic er, output int lat);
    int n;
    set_req(sel, 1'b1, w, a, d, f);
    n = 0;
    while (!rdy(sel) && n < 20) begin
      tick();
      n++;
    end
    tick();
    set_req(sel, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    lat = 1;
    while (!vld(sel) && lat < 40) begin
      tick();
      lat++;
    end
    if (!vld(sel)) lat = -1;
    rd = (sel == 0) ? bus_a.rsp_rdata : bus_b.rsp_rdata;
    er = (sel == 0) ? bus_a.rsp_error : bus_b.rsp_error;
    tick();
  endtask

  task automatic do_load(input int sel, input string tag, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic er;
    int lat;
    xact(sel, 1'b0, a, 32'd0, f, rd, er, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, rd, exp_data);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  task automatic do_store(input int sel, input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic er;
    int lat;
    xact(sel, 1'b1, a, d, f, rd, er, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, rd, 32'd0);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  initial begin
    int hi;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    bus_a.rsp_ready = 1'b1;
    bus_b.rsp_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus_a.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
    chk("rst_rsp_error", {31'd0, bus_a.rsp_error}, 32'd0);
    chk("rst_b_req_ready", {31'd0, bus_b.req_ready}, 32'd1);
    chk("rst_b_rsp_valid", {31'd0, bus_b.rsp_valid}, 32'd0);

    do_store(0, "sw_4", 32'h0001_0004, 32'hDEAD_BEEF, F_SW, 1'b0, 3);
    do_load (0, "lw_4", 32'h0001_0004, F_LW, 32'hDEAD_BEEF, 1'b0, 3);

    do_load(0, "lb_7",  32'h0001_0007, F_LB,  32'hFFFF_FFDE, 1'b0, 3);
    do_load(0, "lbu_7", 32'h0001_0007, F_LBU, 32'h0000_00DE, 1'b0, 3);
    do_load(0, "lh_4",  32'h0001_0004, F_LH,  32'hFFFF_BEEF, 1'b0, 3);
    do_load(0, "lhu_6", 32'h0001_0006, F_LHU, 32'h0000_DEAD, 1'b0, 3);

    do_store(0, "sb_5", 32'h0001_0005, 32'h0000_0012, F_SB, 1'b0, 3);
    do_load (0, "lw_sb", 32'h0001_0004, F_LW, 32'hDEAD_12EF, 1'b0, 3);
    do_store(0, "sh_6", 32'h0001_0006, 32'h0000_5678, F_SH, 1'b0, 3);
    do_load (0, "lw_sh", 32'h0001_0004, F_LW, 32'h5678_12EF, 1'b0, 3);

    // Faulting accesses around word 0 must leave it untouched.
    do_store(0, "sw_0", 32'h0001_0000, 32'h0BAD_F00D, F_SW, 1'b0, 3);
    do_load (0, "lw_mis", 32'h0001_0002, F_LW, 32'd0, 1'b1, 3);
    do_store(0, "sh_mis", 32'h0001_0001, 32'h0000_FFFF, F_SH, 1'b1, 3);
    do_load (0, "lw_low", 32'h0000_FFFC, F_LW, 32'd0, 1'b1, 3);
    do_load (0, "ld_f011", 32'h0001_0000, 3'b011, 32'd0, 1'b1, 3);
    do_store(0, "sw_high", 32'h0001_1000, 32'hFFFF_FFFF, F_SW, 1'b1, 3);
    do_store(0, "s_f100", 32'h0001_0000, 32'hFFFF_FFFF, 3'b100, 1'b1, 3);
    do_load (0, "lw_0", 32'h0001_0000, F_LW, 32'h0BAD_F00D, 1'b0, 3);

    do_store(0, "sw_last", 32'h0001_0FFC, 32'h1357_9BDF, F_SW, 1'b0, 3);
    do_load (0, "lw_last", 32'h0001_0FFC, F_LW, 32'h1357_9BDF, 1'b0, 3);

    // Backpressure: response held, a stray request pulse is not taken.
    bus_a.rsp_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0001_0004, 32'd0, F_LW);
    tick();
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    hi = 1;
    while (!bus_a.rsp_valid && hi < 40) begin
      tick();
      hi++;
    end
    chk("hold_lat", 32'(hi), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, bus_a.rsp_valid}, 32'd1);
      chk("hold_rdata", bus_a.rsp_rdata, 32'h5678_12EF);
      chk("hold_error", {31'd0, bus_a.rsp_error}, 32'd0);
      chk("hold_req_ready", {31'd0, bus_a.req_ready}, 32'd0);
      if (i == 1) set_req(0, 1'b1, 1'b1, 32'h0001_0004, 32'hFFFF_FFFF, F_SW);
      if (i == 2) set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      tick();
    end
    bus_a.rsp_ready = 1'b1;
    tick();
    chk("hold_release", {31'd0, bus_a.rsp_valid}, 32'd0);
    do_load(0, "lw_after_hold", 32'h0001_0004, F_LW, 32'h5678_12EF, 1'b0, 3);

    // Reset in the first wait cycle aborts the store.
    do_store(0, "sw_8_prior", 32'h0001_0008, 32'h1122_3344, F_SW, 1'b0, 3);
    set_req(0, 1'b1, 1'b1, 32'h0001_0008, 32'hAAAA_AAAA, F_SW);
    tick();
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus_a.rsp_valid) hi++;
      tick();
    end
    chk("abort_no_rsp", 32'(hi), 32'd0);
    chk("abort_req_ready", {31'd0, bus_a.req_ready}, 32'd1);
    do_load(0, "lw_8_abort", 32'h0001_0008, F_LW, 32'h1122_3344, 1'b0, 3);

    // Zero wait states: response one cycle after acceptance; reset in RESP keeps the write.
    do_store(1, "b_sw_10", 32'h0001_0010, 32'hCAFE_F00D, F_SW, 1'b0, 1);
    do_load (1, "b_lw_10", 32'h0001_0010, F_LW, 32'hCAFE_F00D, 1'b0, 1);
    do_load (1, "b_lh_mis", 32'h0001_0011, F_LH, 32'd0, 1'b1, 1);
    bus_b.rsp_ready = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'h0001_0014, 32'h55AA_55AA, F_SW);
    tick();
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    chk("b_resp_visible", {31'd0, bus_b.rsp_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("b_resp_dropped", {31'd0, bus_b.rsp_valid}, 32'd0);
    bus_b.rsp_ready = 1'b1;
    tick();
    do_load(1, "b_lw_14", 32'h0001_0014, F_LW, 32'h55AA_55AA, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
